// File: rtl/ptw_pkg.sv
// Constants and types shared between the translation cache and the page-table walker.
package ptw_pkg;

  localparam int unsigned DefAddrW     = 48;
  localparam int unsigned DefVmidW     = 8;
  localparam int unsigned DefPageShift = 12;
  localparam int unsigned DefVpnW      = DefAddrW - DefPageShift;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWalk
  } tlb_state_t;

  typedef struct packed {
    logic                valid;
    logic [DefVmidW-1:0] vmid;
    logic [DefVpnW-1:0]  vpn;
    logic [DefVpnW-1:0]  ppn;
  } tlb_entry_t;

endpackage

// File: rtl/tlb_victim_sel.sv
// Refill victim choice: the lowest-index invalid entry wins. If every entry is valid, the
// round-robin pointer picks the victim and is then advanced.
module tlb_victim_sel #(
  parameter int unsigned ENTRIES = 8,
  localparam int unsigned IdxW   = $clog2(ENTRIES)
) (
  input  logic [ENTRIES-1:0] valid,
  input  logic [IdxW-1:0]    rr_ptr,
  output logic [IdxW-1:0]    victim,
  output logic [IdxW-1:0]    rr_ptr_next
);

  always_comb begin
    victim      = rr_ptr;
    rr_ptr_next = rr_ptr + 1'b1;
    // Descending scan, so the lowest invalid index is the last one written.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        victim      = IdxW'(i);
        rr_ptr_next = rr_ptr;
      end
    end
  end

endmodule

// File: rtl/tlb_walk_cache.sv
// Blocking, fully-associative translation cache in front of the page-table walker. It allows one
// outstanding walk and supports VMID or global invalidation and saturating hit/miss counters.
module tlb_walk_cache
  import ptw_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned VMID_W     = DefVmidW,
  parameter int unsigned ENTRIES    = 8,
  parameter int unsigned PAGE_SHIFT = DefPageShift,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lk_v,
  input  logic [ADDR_W-1:0] lk_va,
  input  logic [VMID_W-1:0] lk_vmid,
  output logic              lk_rdy,
  output logic              lk_resp_v,
  output logic [ADDR_W-1:0] lk_resp_pa,
  output logic              lk_resp_fault,
  output logic              ptw_req_v,
  output logic [ADDR_W-1:0] ptw_req_va,
  output logic [VMID_W-1:0] ptw_req_vmid,
  input  logic              ptw_req_ack,
  input  logic              ptw_resp_v,
  input  logic [ADDR_W-1:0] ptw_resp_pa,
  input  logic              ptw_resp_fault,
  input  logic [VMID_W-1:0] ptw_resp_vmid,
  input  logic              inv_v,
  input  logic              inv_all,
  input  logic [VMID_W-1:0] inv_vmid,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int unsigned IdxW = $clog2(ENTRIES);

  tlb_state_t        state_q, state_d;
  tlb_entry_t        entries_q [ENTRIES];
  logic [ADDR_W-1:0] va_q;
  logic [VMID_W-1:0] vmid_q;
  logic              discard_q, discard_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_next, victim;
  logic [ENTRIES-1:0] valid_vec;
  logic              hit;
  logic [IdxW-1:0]   hit_idx;
  logic              resp_v_q, resp_fault_q;
  logic [ADDR_W-1:0] resp_pa_q;
  logic [CNT_W-1:0]  hit_cnt_q, miss_cnt_q;

  logic lk_fire, lk_hit, lk_miss, inv_hits_walk, walk_done, walk_fault, refill;

  // At most one entry can match, because refills are serialised behind a single walk.
  always_comb begin
    valid_vec = '0;
    hit       = 1'b0;
    hit_idx   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      valid_vec[i] = entries_q[i].valid;
      if (entries_q[i].valid && entries_q[i].vmid == lk_vmid &&
          entries_q[i].vpn == lk_va[ADDR_W-1:PAGE_SHIFT]) begin
        hit     = 1'b1;
        hit_idx = IdxW'(i);
      end
    end
  end

  tlb_victim_sel #(
    .ENTRIES (ENTRIES)
  ) u_victim_sel (
    .valid       (valid_vec),
    .rr_ptr      (rr_ptr_q),
    .victim      (victim),
    .rr_ptr_next (rr_ptr_next)
  );

  assign lk_rdy        = rst_n && (state_q == StIdle) && !inv_v;
  assign lk_fire       = lk_v && lk_rdy;
  assign lk_hit        = lk_fire && hit;
  assign lk_miss       = lk_fire && !hit;
  assign inv_hits_walk = inv_v && (inv_all || inv_vmid == vmid_q);
  assign walk_done     = (state_q == StWalk) && ptw_resp_v;
  assign walk_fault    = ptw_resp_fault || (ptw_resp_vmid != vmid_q);
  // An invalidate that lands in the same cycle as the response must also block the refill.
  assign refill        = walk_done && !walk_fault && !discard_q && !inv_hits_walk;

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    unique case (state_q)
      StIdle: begin
        discard_d = 1'b0;
        if (lk_miss) state_d = StReq;
      end
      StReq: begin
        discard_d = discard_q || inv_hits_walk;
        if (ptw_req_ack) state_d = StWalk;
      end
      StWalk: begin
        if (ptw_resp_v) begin
          state_d   = StIdle;
          discard_d = 1'b0;
        end else begin
          discard_d = discard_q || inv_hits_walk;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      discard_q <= 1'b0;
      va_q      <= '0;
      vmid_q    <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      if (lk_miss) begin
        va_q   <= lk_va;
        vmid_q <= lk_vmid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) entries_q[i] <= '0;
      rr_ptr_q <= '0;
    end else begin
      if (inv_v) begin
        for (int i = 0; i < ENTRIES; i++) begin
          if (inv_all || entries_q[i].vmid == inv_vmid) entries_q[i].valid <= 1'b0;
        end
      end
      if (refill) begin
        entries_q[victim] <= '{valid: 1'b1,
                               vmid:  vmid_q,
                               vpn:   va_q[ADDR_W-1:PAGE_SHIFT],
                               ppn:   ptw_resp_pa[ADDR_W-1:PAGE_SHIFT]};
        rr_ptr_q <= rr_ptr_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_v_q     <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_pa_q    <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      resp_v_q     <= lk_hit || walk_done;
      resp_fault_q <= 1'b0;
      resp_pa_q    <= '0;
      if (lk_hit) begin
        resp_pa_q <= {entries_q[hit_idx].ppn, lk_va[PAGE_SHIFT-1:0]};
      end else if (walk_done) begin
        resp_fault_q <= walk_fault;
        resp_pa_q    <= walk_fault ? '0 : (ptw_resp_pa | ADDR_W'(va_q[PAGE_SHIFT-1:0]));
      end
      if (lk_hit && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
      if (lk_miss && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  assign lk_resp_v     = resp_v_q;
  assign lk_resp_pa    = resp_pa_q;
  assign lk_resp_fault = resp_fault_q;
  assign ptw_req_v     = (state_q == StReq);
  assign ptw_req_va    = va_q;
  assign ptw_req_vmid  = vmid_q;
  assign hit_cnt       = hit_cnt_q;
  assign miss_cnt      = miss_cnt_q;

endmodule

// File: tb/tb_tlb_walk_cache.sv
// Randomised bench for tlb_walk_cache: an array-based translation-cache model predicts hits,
// walks, responses, refills and counters from the cache's external rules.
module tb_tlb_walk_cache;

  localparam int ADDR_W = 48;
  localparam int VMID_W = 8;
  localparam int ENT    = 8;

  logic              clk, rst_n;
  logic              lk_v, lk_rdy, lk_resp_v, lk_resp_fault;
  logic [ADDR_W-1:0] lk_va, lk_resp_pa;
  logic [VMID_W-1:0] lk_vmid;
  logic              ptw_req_v, ptw_req_ack, ptw_resp_v, ptw_resp_fault;
  logic [ADDR_W-1:0] ptw_req_va, ptw_resp_pa;
  logic [VMID_W-1:0] ptw_req_vmid, ptw_resp_vmid;
  logic              inv_v, inv_all;
  logic [VMID_W-1:0] inv_vmid;
  logic [31:0]       hit_cnt, miss_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_valid [ENT];
  logic [7:0]  m_vmid  [ENT];
  logic [35:0] m_vpn   [ENT];
  logic [35:0] m_ppn   [ENT];
  int          m_rr;
  logic [31:0] m_hits, m_misses;

  tlb_walk_cache u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lk_v           (lk_v),
    .lk_va          (lk_va),
    .lk_vmid        (lk_vmid),
    .lk_rdy         (lk_rdy),
    .lk_resp_v      (lk_resp_v),
    .lk_resp_pa     (lk_resp_pa),
    .lk_resp_fault  (lk_resp_fault),
    .ptw_req_v      (ptw_req_v),
    .ptw_req_va     (ptw_req_va),
    .ptw_req_vmid   (ptw_req_vmid),
    .ptw_req_ack    (ptw_req_ack),
    .ptw_resp_v     (ptw_resp_v),
    .ptw_resp_pa    (ptw_resp_pa),
    .ptw_resp_fault (ptw_resp_fault),
    .ptw_resp_vmid  (ptw_resp_vmid),
    .inv_v          (inv_v),
    .inv_all        (inv_all),
    .inv_vmid       (inv_vmid),
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < ENT; i++) m_valid[i] = 1'b0;
    m_rr     = 0;
    m_hits   = 0;
    m_misses = 0;
  endfunction

  function automatic int model_find(input logic [47:0] va, input logic [7:0] vmid);
    model_find = -1;
    for (int i = 0; i < ENT; i++)
      if (m_valid[i] && m_vmid[i] == vmid && m_vpn[i] == va[47:12]) model_find = i;
  endfunction

  function automatic void model_inv(input bit all, input logic [7:0] vmid);
    for (int i = 0; i < ENT; i++) if (all || m_vmid[i] == vmid) m_valid[i] = 1'b0;
  endfunction

  function automatic void model_refill(input logic [47:0] va, input logic [7:0] vmid,
                                       input logic [47:0] pa);
    int v = -1;
    for (int i = 0; i < ENT; i++) if (!m_valid[i] && v < 0) v = i;
    if (v < 0) begin
      v    = m_rr;
      m_rr = (m_rr + 1) % ENT;
    end
    m_valid[v] = 1'b1;
    m_vmid[v]  = vmid;
    m_vpn[v]   = va[47:12];
    m_ppn[v]   = pa[47:12];
  endfunction

  // inv_mode during the walk: 0 none, 1 outstanding vmid, 2 global, 3 unrelated vmid
  task automatic lookup(input logic [47:0] va, input logic [7:0] vmid, input logic [47:0] pa,
                        input bit fault, input bit bad_vmid, input int inv_mode);
    int          idx;
    bit          exp_fault, discard;
    logic [47:0] exp_pa;
    @(negedge clk);
    check_eq("lk_rdy_idle", lk_rdy, 1);
    lk_v = 1'b1; lk_va = va; lk_vmid = vmid;
    idx = model_find(va, vmid);
    @(negedge clk);
    lk_v = 1'b0;
    if (idx >= 0) begin
      if (m_hits != 32'hFFFF_FFFF) m_hits++;
      check_eq("hit_resp_v", lk_resp_v, 1);
      check_eq("hit_pa", lk_resp_pa, {m_ppn[idx], va[11:0]});
      check_eq("hit_fault", lk_resp_fault, 0);
      check_eq("hit_no_req", ptw_req_v, 0);
    end else begin
      if (m_misses != 32'hFFFF_FFFF) m_misses++;
      check_eq("miss_no_resp", lk_resp_v, 0);
      check_eq("req_v", ptw_req_v, 1);
      check_eq("req_va", ptw_req_va, va);
      check_eq("req_vmid", ptw_req_vmid, vmid);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check_eq("req_hold", ptw_req_v, 1);
      end
      ptw_req_ack = 1'b1;
      @(negedge clk);
      ptw_req_ack = 1'b0;
      check_eq("req_drop", ptw_req_v, 0);
      discard = 1'b0;
      if (inv_mode != 0) begin
        inv_v = 1'b1; inv_all = (inv_mode == 2);
        inv_vmid = (inv_mode == 3) ? (vmid ^ 8'h80) : vmid;
        model_inv(inv_mode == 2, inv_vmid);
        discard = (inv_mode == 1) || (inv_mode == 2);
        #1 check_eq("rdy_walk", lk_rdy, 0);
        @(negedge clk);
        inv_v = 1'b0; inv_all = 1'b0;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ptw_resp_v = 1'b1; ptw_resp_pa = pa; ptw_resp_fault = fault;
      ptw_resp_vmid = bad_vmid ? (vmid ^ 8'h01) : vmid;
      @(negedge clk);
      ptw_resp_v = 1'b0; ptw_resp_fault = 1'b0;
      exp_fault = fault || bad_vmid;
      exp_pa    = exp_fault ? 48'h0 : (pa | {36'h0, va[11:0]});
      check_eq("walk_resp_v", lk_resp_v, 1);
      check_eq("walk_pa", lk_resp_pa, exp_pa);
      check_eq("walk_fault", lk_resp_fault, exp_fault);
      if (!exp_fault && !discard) model_refill(va, vmid, pa);
    end
    check_eq("hit_cnt", hit_cnt, m_hits);
    check_eq("miss_cnt", miss_cnt, m_misses);
  endtask

  task automatic inv_idle(input bit all, input logic [7:0] vmid);
    @(negedge clk);
    inv_v = 1'b1; inv_all = all; inv_vmid = vmid;
    lk_v = 1'b1; lk_va = {36'h100, 12'h0}; lk_vmid = vmid;
    #1 check_eq("rdy_blocked", lk_rdy, 0);
    @(negedge clk);
    inv_v = 1'b0; inv_all = 1'b0; lk_v = 1'b0;
    model_inv(all, vmid);
    check_eq("inv_no_resp", lk_resp_v, 0);
    check_eq("inv_no_req", ptw_req_v, 0);
  endtask

  task automatic stray_resp();
    @(negedge clk);
    ptw_resp_v = 1'b1; ptw_resp_pa = 48'hDEAD_BEEF_F000; ptw_resp_vmid = 8'h0;
    @(negedge clk);
    ptw_resp_v = 1'b0;
    check_eq("stray_ignored", lk_resp_v, 0);
  endtask

  function automatic logic [47:0] rand_pa();
    rand_pa = {$urandom_range(0, 32'hFFFF), $urandom(), 12'h0};
    rand_pa[11:0] = 12'h0;
  endfunction

  logic [47:0] va, pg;

  initial begin
    rst_n = 1'b0; lk_v = 1'b0; lk_va = '0; lk_vmid = '0;
    ptw_req_ack = 1'b0; ptw_resp_v = 1'b0; ptw_resp_pa = '0; ptw_resp_fault = 1'b0;
    ptw_resp_vmid = '0; inv_v = 1'b0; inv_all = 1'b0; inv_vmid = '0;
    model_reset();
    #1;
    check_eq("rst_rdy", lk_rdy, 0);
    check_eq("rst_resp_v", lk_resp_v, 0);
    check_eq("rst_req_v", ptw_req_v, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_rdy", lk_rdy, 1);
    check_eq("post_rst_hits", hit_cnt, 0);
    check_eq("post_rst_miss", miss_cnt, 0);

    // Cold miss then re-hit
    lookup(48'h1234_5678, 8'd3, 48'hABC000, 1'b0, 1'b0, 0);
    lookup(48'h1234_5678, 8'd3, 48'h0, 1'b0, 1'b0, 0);
    // Faults and vmid-echo mismatches are not cached
    lookup(48'h5555_5123, 8'd1, 48'h777000, 1'b1, 1'b0, 0);
    lookup(48'h5555_5123, 8'd1, 48'h777000, 1'b0, 1'b1, 0);
    lookup(48'h5555_5123, 8'd1, 48'h777000, 1'b0, 1'b0, 0);
    lookup(48'h5555_5FFF, 8'd1, 48'h0, 1'b0, 1'b0, 0);
    // Replacement: nine pages into eight entries, then page 1 and page 0
    inv_idle(1'b1, 8'd0);
    for (int k = 0; k < 9; k++) lookup({36'h2000 + 36'(k), 12'h010}, 8'd5, rand_pa(), 0, 0, 0);
    lookup({36'h2001, 12'h020}, 8'd5, rand_pa(), 0, 0, 0);
    lookup({36'h2000, 12'h030}, 8'd5, rand_pa(), 0, 0, 0);
    // Invalidate of the outstanding vmid during the walk suppresses refill
    lookup(48'h3333_3444, 8'd3, 48'h999000, 1'b0, 1'b0, 1);
    lookup(48'h3333_3444, 8'd3, 48'h999000, 1'b0, 1'b0, 0);
    stray_resp();

    for (int n = 0; n < 300; n++) begin
      int sel;
      sel = $urandom_range(0, 19);
      va  = {36'h100 + 36'($urandom_range(0, 11)), 12'($urandom())};
      if (sel == 0) inv_idle($urandom_range(0, 3) == 0, 8'($urandom_range(0, 2)));
      else if (sel == 1) stray_resp();
      else
        lookup(va, 8'($urandom_range(0, 2)), rand_pa(), $urandom_range(0, 9) == 0,
               $urandom_range(0, 14) == 0, (sel < 5) ? int'($urandom_range(1, 3)) : 0);
    end

    // Reset in the middle of a walk
    pg = 48'h4444_4abc;
    lookup(pg, 8'd2, 48'h123000, 1'b0, 1'b0, 0);
    lookup(pg, 8'd2, 48'h0, 1'b0, 1'b0, 0);
    @(negedge clk);
    lk_v = 1'b1; lk_va = 48'h6666_6000; lk_vmid = 8'd2;
    @(negedge clk);
    lk_v = 1'b0;
    check_eq("mw_req_v", ptw_req_v, 1);
    ptw_req_ack = 1'b1;
    @(negedge clk);
    ptw_req_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("mw_rdy", lk_rdy, 0);
    check_eq("mw_req_v0", ptw_req_v, 0);
    check_eq("mw_req_va", ptw_req_va, 0);
    check_eq("mw_req_vmid", ptw_req_vmid, 0);
    check_eq("mw_resp_v", lk_resp_v, 0);
    check_eq("mw_resp_pa", lk_resp_pa, 0);
    check_eq("mw_resp_fault", lk_resp_fault, 0);
    check_eq("mw_hits", hit_cnt, 0);
    check_eq("mw_miss", miss_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    lookup(pg, 8'd2, 48'h456000, 1'b0, 1'b0, 0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
